pixel_bist_engine: RTL and testbench

- Parametrised built-in self-test engine for the pixel pipeline; successor to the fixed 8-bit LFSR plus signature-analyzer pair.
- Generates a programmable number of pseudo-random pixels with a Galois LFSR and drives them to the pipeline over a valid/ready handshake.
- Compacts the returned pixels into a MISR and compares the final signature against a loaded golden value.
- Reports done, pass and timeout; sits between the SPI control path and the gray/sobel core.

---
 rtl/pixel_bist_pkg.sv | 16 +
 rtl/pixel_bist_engine_misr.sv | 31 +++
 rtl/pixel_bist_engine.sv | 177 +++++++++++++++++
 tb/tb_pixel_bist_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_bist_pkg.sv
// Shared types and defaults for the pixel pipeline BIST engine.
package pixel_bist_pkg;

  localparam int unsigned MAX_PIXEL_BITS    = 8;
  localparam int unsigned DATA_W_DEFAULT    = MAX_PIXEL_BITS;
  localparam logic [7:0]  LFSR_TAPS_DEFAULT = 8'hB8;
  localparam logic [7:0]  MISR_TAPS_DEFAULT = 8'h1D;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } bist_state_t;

endpackage

// File: rtl/pixel_bist_engine_misr.sv
// Multiple-input signature register compacting returned pixels.
module bist_misr
  import pixel_bist_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] MISR_TAPS = DATA_W'(MISR_TAPS_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sig_o,
  output logic [DATA_W-1:0] sig_next_o
);

  // Shift-left with feedback from the MSB, folding in the incoming pixel.
  always_comb begin
    sig_next_o = {sig_o[DATA_W-2:0], 1'b0} ^ (sig_o[DATA_W-1] ? MISR_TAPS : '0) ^ data_i;
  end

  // Signature register: cleared on reset or run start, steps on accepted data.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      sig_o <= '0;
    end else if (en_i) begin
      sig_o <= sig_next_o;
    end
  end

endmodule

// File: rtl/pixel_bist_engine.sv
// Pixel pipeline BIST engine: Galois LFSR pattern source, MISR response
// compactor, golden compare and DRAIN timeout.
// Optional: define PIXEL_BIST_ABORT_EN to add the abort_i input.
module pixel_bist_engine
  import pixel_bist_pkg::*;
#(
  parameter int unsigned       DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned       PATTERN_COUNT  = 1024,
  parameter int unsigned       RESP_COUNT     = PATTERN_COUNT,
  parameter logic [DATA_W-1:0] LFSR_TAPS      = DATA_W'(LFSR_TAPS_DEFAULT),
  parameter logic [DATA_W-1:0] MISR_TAPS      = DATA_W'(MISR_TAPS_DEFAULT),
  parameter int unsigned       TIMEOUT_CYCLES = 256
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
`ifdef PIXEL_BIST_ABORT_EN
  input  logic                               abort_i,
`endif
  input  logic                               start_i,
  input  logic                               seed_load_i,
  input  logic [DATA_W-1:0]                  seed_i,
  input  logic                               golden_load_i,
  input  logic [DATA_W-1:0]                  golden_i,
  output logic [DATA_W-1:0]                  pat_data_o,
  output logic                               pat_valid_o,
  input  logic                               pat_ready_i,
  input  logic [DATA_W-1:0]                  resp_data_i,
  input  logic                               resp_valid_i,
  output logic [DATA_W-1:0]                  signature_o,
  output logic [$clog2(PATTERN_COUNT+1)-1:0] pat_cnt_o,
  output logic [$clog2(RESP_COUNT+1)-1:0]    resp_cnt_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               pass_o,
  output logic                               timeout_o
);

  localparam int unsigned PW = $clog2(PATTERN_COUNT + 1);
  localparam int unsigned RW = $clog2(RESP_COUNT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PAT_LAST  = PW'(PATTERN_COUNT);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESP_COUNT);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES);

  bist_state_t       state, state_n;
  logic [DATA_W-1:0] lfsr, lfsr_step, golden, golden_n;
  logic [DATA_W-1:0] sig, sig_step, sig_n;
  logic [PW-1:0]     pat_cnt, pat_cnt_n;
  logic [RW-1:0]     resp_cnt, resp_cnt_n;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic              pass_q, timeout_q, timeout_d;
  logic              busy, run_start, abort_act, pat_acc, resp_acc, complete, expired;

`ifdef PIXEL_BIST_ABORT_EN
  assign abort_act = busy & abort_i;
`else
  assign abort_act = 1'b0;
`endif

  // Handshake qualification and next values of the run bookkeeping.
  // Completion and timeout look at next-cycle counts so a final pattern and
  // final response landing together still reach DONE one cycle later.
  always_comb begin
    busy       = (state == RUN) || (state == DRAIN);
    run_start  = !busy && start_i;
    pat_acc    = (state == RUN) && pat_ready_i && !abort_act;
    resp_acc   = busy && resp_valid_i && (resp_cnt < RESP_LAST) && !abort_act;
    pat_cnt_n  = pat_cnt + PW'(pat_acc);
    resp_cnt_n = resp_cnt + RW'(resp_acc);
    to_cnt_n   = to_cnt;
    if (resp_acc) begin
      to_cnt_n = '0;
    end else if ((state == DRAIN) && !abort_act) begin
      to_cnt_n = to_cnt + TW'(1);
    end
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    golden_n  = golden_load_i ? golden_i : golden;
    sig_n     = resp_acc ? sig_step : sig;
    complete  = busy && (pat_cnt_n == PAT_LAST) && (resp_cnt_n == RESP_LAST);
    expired   = (state == DRAIN) && (to_cnt_n == TO_LAST);
    timeout_d = abort_act || (expired && !complete);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start_i) state_n = RUN;
      end
      RUN, DRAIN: begin
        if (abort_act || complete || expired) begin
          state_n = DONE;
        end else if ((state == RUN) && (pat_cnt_n == PAT_LAST)) begin
          state_n = DRAIN;
        end
      end
    endcase
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    pat_valid_o = (state == RUN);
    busy_o      = busy;
    done_o      = (state == DONE);
    pat_data_o  = lfsr;
    signature_o = sig;
    pat_cnt_o   = pat_cnt;
    resp_cnt_o  = resp_cnt;
    pass_o      = pass_q;
    timeout_o   = timeout_q;
  end

  // LFSR, golden register and run counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr     <= DATA_W'(1);
      golden   <= '0;
      pat_cnt  <= '0;
      resp_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      golden <= golden_n;
      if (!busy && seed_load_i) begin
        lfsr <= (seed_i == '0) ? DATA_W'(1) : seed_i;
      end else if (pat_acc) begin
        lfsr <= lfsr_step;
      end
      if (run_start) begin
        pat_cnt  <= '0;
        resp_cnt <= '0;
        to_cnt   <= '0;
      end else begin
        pat_cnt  <= pat_cnt_n;
        resp_cnt <= resp_cnt_n;
        to_cnt   <= to_cnt_n;
      end
    end
  end

  // Verdict: captured on DONE entry, re-evaluated in DONE so a late golden
  // load shows up one cycle after it is presented.
  always_ff @(posedge clk_i) begin
    if (reset_i || run_start) begin
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (busy && (state_n == DONE)) begin
      timeout_q <= timeout_d;
      pass_q    <= (sig_n == golden_n) && !timeout_d;
    end else if (state == DONE) begin
      pass_q <= (sig == golden_n) && !timeout_q;
    end
  end

  bist_misr #(
    .DATA_W    (DATA_W),
    .MISR_TAPS (MISR_TAPS)
  ) u_misr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (run_start),
    .en_i       (resp_acc),
    .data_i     (resp_data_i),
    .sig_o      (sig),
    .sig_next_o (sig_step)
  );

endmodule

// File: tb/tb_pixel_bist_engine.sv
// Self-checking bench for pixel_bist_engine: directed scenarios followed by
// randomized traffic, all compared against a behavioural run model.
module tb_pixel_bist_engine;

  localparam int PC = 4;
  localparam int RC = 3;
  localparam int TO = 8;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset, start, seed_load, golden_load, pat_ready, resp_valid;
  logic [7:0] seed, golden, resp_data;
  logic [7:0] pat_data, signature;
  logic       pat_valid, busy, done, pass, timeout;
  logic [2:0] pat_cnt;
  logic [1:0] resp_cnt;
`ifdef PIXEL_BIST_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int m_st, m_lfsr, m_gold, m_sig, m_pc, m_rc, m_to;
  bit m_pass, m_tmo;
  int dens;

  always #5 clk = ~clk;

  pixel_bist_engine #(
    .DATA_W         (8),
    .PATTERN_COUNT  (PC),
    .RESP_COUNT     (RC),
    .LFSR_TAPS      (8'hB8),
    .MISR_TAPS      (8'h1D),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
`ifdef PIXEL_BIST_ABORT_EN
    .abort_i       (abort),
`endif
    .reset_i       (reset),
    .start_i       (start),
    .seed_load_i   (seed_load),
    .seed_i        (seed),
    .golden_load_i (golden_load),
    .golden_i      (golden),
    .pat_data_o    (pat_data),
    .pat_valid_o   (pat_valid),
    .pat_ready_i   (pat_ready),
    .resp_data_i   (resp_data),
    .resp_valid_i  (resp_valid),
    .signature_o   (signature),
    .pat_cnt_o     (pat_cnt),
    .resp_cnt_o    (resp_cnt),
    .busy_o        (busy),
    .done_o        (done),
    .pass_o        (pass),
    .timeout_o     (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int x);
    return (x >> 1) ^ (((x & 1) != 0) ? 'hB8 : 0);
  endfunction

  function automatic int misr_next(input int s, input int d);
    return ((s << 1) & 'hFF) ^ (((s & 'h80) != 0) ? 'h1D : 0) ^ d;
  endfunction

  // One clock of the run model, using the inputs presented before the edge.
  task automatic model_clock();
    int  g_n;
    bit  pacc, racc;
    g_n = golden_load ? int'(golden) : m_gold;
    if (reset) begin
      m_st = S_IDLE; m_lfsr = 1; m_gold = 0; m_sig = 0;
      m_pc = 0; m_rc = 0; m_to = 0; m_pass = 0; m_tmo = 0;
      return;
    end
    if (m_st == S_IDLE || m_st == S_DONE) begin
      if (seed_load) m_lfsr = (seed == 0) ? 1 : int'(seed);
      if (start) begin
        m_st = S_RUN; m_sig = 0; m_pc = 0; m_rc = 0; m_to = 0; m_pass = 0; m_tmo = 0;
      end else if (m_st == S_DONE) begin
        m_pass = (m_sig == g_n) && !m_tmo;
      end
    end else begin
      pacc = (m_st == S_RUN) && pat_ready;
      racc = resp_valid && (m_rc < RC);
      if (pacc) begin
        m_lfsr = lfsr_next(m_lfsr);
        m_pc++;
      end
      if (racc) begin
        m_sig = misr_next(m_sig, int'(resp_data));
        m_rc++;
        m_to = 0;
      end else if (m_st == S_DRAIN) begin
        m_to++;
      end
      if (m_pc == PC && m_rc == RC) begin
        m_st = S_DONE; m_tmo = 0; m_pass = (m_sig == g_n);
      end else if (m_st == S_DRAIN && m_to == TO) begin
        m_st = S_DONE; m_tmo = 1; m_pass = 0;
      end else if (m_st == S_RUN && m_pc == PC) begin
        m_st = S_DRAIN;
      end
    end
    m_gold = g_n;
  endtask

  task automatic compare_all();
    check_eq("pat_data", pat_data, m_lfsr);
    check_eq("pat_valid", pat_valid, m_st == S_RUN);
    check_eq("signature", signature, m_sig);
    check_eq("pat_cnt", pat_cnt, m_pc);
    check_eq("resp_cnt", resp_cnt, m_rc);
    check_eq("busy", busy, (m_st == S_RUN) || (m_st == S_DRAIN));
    check_eq("done", done, m_st == S_DONE);
    check_eq("pass", pass, m_pass);
    check_eq("timeout", timeout, m_tmo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; start = 1'b0; seed_load = 1'b0; golden_load = 1'b0;
    pat_ready = 1'b0; resp_valid = 1'b0; seed = '0; golden = '0; resp_data = '0;
    m_st = S_IDLE; m_lfsr = 1; m_gold = 0; m_sig = 0;
    m_pc = 0; m_rc = 0; m_to = 0; m_pass = 0; m_tmo = 0;

    // Reset state
    tick();
    reset = 1'b0;
    check_eq("rst_pat_data", pat_data, 8'h01);
    check_eq("rst_signature", signature, 8'h00);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);

    // Zero seed is replaced by 1
    seed_load = 1'b1; seed = 8'h00;
    tick();
    seed_load = 1'b0;
    check_eq("seed_zero", pat_data, 8'h01);

    // Pattern sequence with a 3-cycle stall on the second pattern
    seed_load = 1'b1; seed = 8'h01; golden_load = 1'b1; golden = 8'h03;
    start = 1'b1; pat_ready = 1'b1;
    tick();
    seed_load = 1'b0; golden_load = 1'b0; start = 1'b0;
    check_eq("pat0", pat_data, 8'h01);
    tick();
    check_eq("pat1", pat_data, 8'hB8);
    pat_ready = 1'b0;
    repeat (3) begin
      tick();
      check_eq("stall_data", pat_data, 8'hB8);
      check_eq("stall_valid", pat_valid, 1'b1);
    end
    pat_ready = 1'b1;
    tick();
    check_eq("pat2", pat_data, 8'h5C);
    tick();
    check_eq("pat3", pat_data, 8'h2E);
    tick();
    pat_ready = 1'b0;
    check_eq("drain_pat_cnt", pat_cnt, 3'd4);
    check_eq("drain_valid", pat_valid, 1'b0);
    check_eq("drain_busy", busy, 1'b1);

    // Responses 01,02,03 against golden 03
    resp_valid = 1'b1;
    resp_data = 8'h01; tick(); check_eq("sig_r1", signature, 8'h01);
    resp_data = 8'h02; tick(); check_eq("sig_r2", signature, 8'h00);
    resp_data = 8'h03; tick(); check_eq("sig_r3", signature, 8'h03);
    resp_valid = 1'b0;
    check_eq("pass_done", done, 1'b1);
    check_eq("pass_pass", pass, 1'b1);
    check_eq("pass_timeout", timeout, 1'b0);

    // Same run with wrong golden, then corrected during DONE
    golden_load = 1'b1; golden = 8'h04; start = 1'b1; pat_ready = 1'b1;
    tick();
    golden_load = 1'b0; start = 1'b0;
    repeat (4) tick();
    pat_ready = 1'b0; resp_valid = 1'b1;
    resp_data = 8'h01; tick();
    resp_data = 8'h02; tick();
    resp_data = 8'h03; tick();
    resp_valid = 1'b0;
    check_eq("bad_done", done, 1'b1);
    check_eq("bad_pass", pass, 1'b0);
    golden_load = 1'b1; golden = 8'h03;
    tick();
    golden_load = 1'b0;
    check_eq("reeval_pass", pass, 1'b1);

    // Timeout: only two of three responses
    start = 1'b1; pat_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    pat_ready = 1'b0; resp_valid = 1'b1;
    resp_data = 8'h11; tick();
    resp_data = 8'h22; tick();
    resp_valid = 1'b0;
    repeat (TO - 1) begin
      tick();
      check_eq("to_early_done", done, 1'b0);
    end
    tick();
    check_eq("to_done", done, 1'b1);
    check_eq("to_timeout", timeout, 1'b1);
    check_eq("to_pass", pass, 1'b0);

    // Reset during RUN
    start = 1'b1; pat_ready = 1'b1;
    tick();
    start = 1'b0; resp_valid = 1'b1; resp_data = 8'h5A;
    tick();
    resp_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; pat_ready = 1'b0;
    check_eq("midrst_pat_data", pat_data, 8'h01);
    check_eq("midrst_valid", pat_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_sig", signature, 8'h00);
    check_eq("midrst_pat_cnt", pat_cnt, 3'd0);

    // Randomized traffic against the model
    dens = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 0;
          1: dens = 10;
          2: dens = 50;
          default: dens = 90;
        endcase
      end
      reset       = ($urandom_range(0, 299) == 0);
      start       = ($urandom_range(0, 9) == 0);
      seed_load   = ($urandom_range(0, 15) == 0);
      seed        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      golden_load = ($urandom_range(0, 15) == 0);
      golden      = ($urandom_range(0, 1) == 0) ? 8'(m_sig) : 8'($urandom_range(0, 255));
      pat_ready   = ($urandom_range(0, 3) != 0);
      resp_valid  = ($urandom_range(0, 99) < dens);
      resp_data   = 8'($urandom_range(0, 255));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
